// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multicycle ALU with iterative shift-add MUL and restoring DIV
// Optional build macro ALU_ZERO_SKIP_EN: trivial MUL/DIV cases finish at accept.
module alu_mc #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [3:0]           opcode_i,
  input  logic [DATAWIDTH-1:0] a_i,
  input  logic [DATAWIDTH-1:0] b_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DATAWIDTH-1:0] out_o,
  output logic                 zero_o,
  output logic                 neg_o,
  output logic                 divz_o,
  output logic                 illegal_o
);

  localparam int CNTW = $clog2(DATAWIDTH + 1);

  localparam logic [3:0] ADD_OP = 4'h0;
  localparam logic [3:0] SUB_OP = 4'h1;
  localparam logic [3:0] MUL_OP = 4'h2;
  localparam logic [3:0] DIV_OP = 4'h3;
  localparam logic [3:0] AND_OP = 4'h4;
  localparam logic [3:0] OR_OP  = 4'h5;
  localparam logic [3:0] XOR_OP = 4'h6;
  localparam logic [3:0] LW_OP  = 4'h7;
  localparam logic [3:0] SW_OP  = 4'h8;
  localparam logic [3:0] JMP_OP = 4'h9;
  localparam logic [3:0] BEQ_OP = 4'hA;
  localparam logic [3:0] BGT_OP = 4'hB;
  localparam logic [3:0] BLT_OP = 4'hC;
  localparam logic [3:0] LI_OP  = 4'hD;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic [DATAWIDTH-1:0] mcand_q, mcand_d;
  logic [DATAWIDTH-1:0] mplier_q, mplier_d;
  logic [DATAWIDTH-1:0] acc_q, acc_d;
  logic [DATAWIDTH-1:0] out_q, out_d;
  logic                 zero_q, zero_d;
  logic                 neg_q, neg_d;
  logic                 divz_q, divz_d;
  logic                 ill_q, ill_d;

  logic                 accept;
  logic                 load;
  logic [DATAWIDTH-1:0] res;
  logic                 res_divz;
  logic                 res_ill;
  logic [DATAWIDTH:0]   rem_shift;
  logic [DATAWIDTH:0]   rem_diff;
  logic                 rem_ge;

  assign in_ready_o  = (state_q == IDLE) | ((state_q == DONE) & out_ready_i);
  assign out_valid_o = (state_q == DONE);
  assign out_o       = out_q;
  assign zero_o      = zero_q;
  assign neg_o       = neg_q;
  assign divz_o      = divz_q;
  assign illegal_o   = ill_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    out_d    = out_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    divz_d   = divz_q;
    ill_d    = ill_q;
    load     = 1'b0;
    res      = '0;
    res_divz = 1'b0;
    res_ill  = 1'b0;

    // DIV reuses the MUL registers: mcand holds the divisor, mplier shifts dividend out and quotient in.
    rem_shift = {acc_q, mplier_q[DATAWIDTH-1]};
    rem_diff  = rem_shift - {1'b0, mcand_q};
    rem_ge    = (rem_shift >= {1'b0, mcand_q});
    accept    = in_valid_i & in_ready_o & ~flush_i;

    if (state_q == BUSY) begin
      cnt_d = cnt_q - CNTW'(1);
      if (is_div_q) begin
        if (rem_ge) begin
          acc_d    = rem_diff[DATAWIDTH-1:0];
          mplier_d = {mplier_q[DATAWIDTH-2:0], 1'b1};
        end else begin
          acc_d    = rem_shift[DATAWIDTH-1:0];
          mplier_d = {mplier_q[DATAWIDTH-2:0], 1'b0};
        end
      end else begin
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
      end
      if (cnt_q == CNTW'(1)) begin
        state_d  = DONE;
        load     = 1'b1;
        res      = is_div_q ? mplier_d : acc_d;
        res_divz = is_div_q & (mcand_q == '0);
      end
    end else if (accept) begin
      state_d = DONE;
      load    = 1'b1;
      case (opcode_i)
        ADD_OP, LW_OP, SW_OP, JMP_OP, BEQ_OP, BGT_OP, BLT_OP, LI_OP: res = a_i + b_i;
        SUB_OP: res = a_i - b_i;
        AND_OP: res = a_i & b_i;
        OR_OP:  res = a_i | b_i;
        XOR_OP: res = a_i ^ b_i;
        MUL_OP, DIV_OP: begin
          load     = 1'b0;
          state_d  = BUSY;
          cnt_d    = CNTW'(DATAWIDTH);
          is_div_d = (opcode_i == DIV_OP);
          mcand_d  = (opcode_i == DIV_OP) ? b_i : a_i;
          mplier_d = (opcode_i == DIV_OP) ? a_i : b_i;
          acc_d    = '0;
          divz_d   = 1'b0;
          ill_d    = 1'b0;
`ifdef ALU_ZERO_SKIP_EN
          if ((opcode_i == MUL_OP) && ((a_i == '0) || (b_i == '0))) begin
            state_d = DONE;
            load    = 1'b1;
            cnt_d   = '0;
          end else if ((opcode_i == DIV_OP) && (b_i == '0)) begin
            state_d  = DONE;
            load     = 1'b1;
            cnt_d    = '0;
            res      = '1;
            res_divz = 1'b1;
          end else if ((opcode_i == DIV_OP) && (a_i < b_i)) begin
            state_d = DONE;
            load    = 1'b1;
            cnt_d   = '0;
          end
`endif
        end
        default: res_ill = 1'b1;
      endcase
    end else if ((state_q == DONE) && out_ready_i) begin
      state_d = IDLE;
    end

    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (load) begin
      out_d  = res;
      zero_d = (res == '0);
      neg_d  = res[DATAWIDTH-1];
      divz_d = res_divz;
      ill_d  = res_ill;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      divz_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      divz_q   <= divz_d;
      ill_q    <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc with a transaction-level reference model
module tb_alu_mc;

  localparam int W = 32;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4, OP_OR = 4'h5, OP_XOR = 4'h6, OP_LW = 4'h7;
  localparam logic [3:0] OP_SW = 4'h8, OP_JMP = 4'h9, OP_BEQ = 4'hA, OP_BGT = 4'hB;
  localparam logic [3:0] OP_BLT = 4'hC, OP_LI = 4'hD;
`ifdef ALU_ZERO_SKIP_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = W + 1;
`endif

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         flush_i = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [3:0]   opcode_i = 4'h0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b1;
  logic [W-1:0] out_o;
  logic         zero_o, neg_o, divz_o, illegal_o;

  alu_mc #(.DATAWIDTH(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .opcode_i(opcode_i),
    .a_i(a_i), .b_i(b_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_o(out_o), .zero_o(zero_o), .neg_o(neg_o), .divz_o(divz_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  task automatic chkv(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic         ill;
    logic         divz;
    logic [W-1:0] res;
  } res_t;

  function automatic res_t ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    r.ill  = 1'b0;
    r.divz = 1'b0;
    r.res  = '0;
    case (op)
      OP_ADD, OP_LW, OP_SW, OP_JMP, OP_BEQ, OP_BGT, OP_BLT, OP_LI: r.res = a + b;
      OP_SUB: r.res = a - b;
      OP_MUL: r.res = a * b;
      OP_DIV: begin
        if (b == 0) begin
          r.res  = '1;
          r.divz = 1'b1;
        end else begin
          r.res = a / b;
        end
      end
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_XOR: r.res = a ^ b;
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op == OP_MUL || op == OP_DIV) begin
`ifdef ALU_ZERO_SKIP_EN
      if (op == OP_MUL && (a == 0 || b == 0)) return 1;
      if (op == OP_DIV && (b == 0 || a < b)) return 1;
`endif
      return W + 1;
    end
    return 1;
  endfunction

  // Model: one outstanding transaction whose result becomes visible at a known cycle.
  int   cyc = 0;
  int   m_due = 0;
  logic m_pend = 1'b0;
  res_t m_res;
  logic m_vld, m_rdy;

  assign m_vld = m_pend && (cyc >= m_due);
  assign m_rdy = !m_pend || (m_vld && out_ready_i);

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_pend <= 1'b0;
      cyc    <= 0;
    end else begin
      cyc <= cyc + 1;
      if (flush_i) begin
        m_pend <= 1'b0;
      end else if (in_valid_i && m_rdy) begin
        m_pend <= 1'b1;
        m_due  <= cyc + ref_lat(opcode_i, a_i, b_i);
        m_res  <= ref_op(opcode_i, a_i, b_i);
      end else if (m_vld && out_ready_i) begin
        m_pend <= 1'b0;
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      chkb("out_valid", out_valid_o, m_vld);
      chkb("in_ready", in_ready_o, m_rdy);
      if (m_vld) begin
        chkv("out", out_o, m_res.res);
        chkb("zero", zero_o, m_res.res == 0);
        chkb("neg", neg_o, m_res.res[W-1]);
        chkb("divz", divz_o, m_res.divz);
        chkb("illegal", illegal_o, m_res.ill);
      end
    end
  end

  // Issue one op from posedge+1, return at the negedge where the result is first valid.
  task automatic op_wait(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
    logic r;
    bit   got;
    in_valid_i = 1'b1;
    opcode_i   = op;
    a_i        = a;
    b_i        = b;
    got        = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_i);
      r = in_ready_o;
      @(posedge clk_i);
      #1;
      got = r;
    end
    in_valid_i = 1'b0;
    if (!got) chkb("accept_timeout", 1'b0, 1'b1);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_i);
      lat++;
      got = out_valid_o;
    end
    if (!got) chkb("result_timeout", 1'b0, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    chkb({tag, "_out_valid"}, out_valid_o, 1'b0);
    chkb({tag, "_in_ready"}, in_ready_o, 1'b1);
    chkv({tag, "_out"}, out_o, '0);
    chkb({tag, "_zero"}, zero_o, 1'b0);
    chkb({tag, "_neg"}, neg_o, 1'b0);
    chkb({tag, "_divz"}, divz_o, 1'b0);
    chkb({tag, "_illegal"}, illegal_o, 1'b0);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return W'($urandom_range(0, 15));
      2: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int   lat;
    logic acc;
    int   seen;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_vals("rst");
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    op_wait(OP_ADD, 32'hFFFF_FFFF, 32'h1, lat);
    chki("add_lat", lat, 1);
    chkv("add_out", out_o, 32'h0);
    chkb("add_zero", zero_o, 1'b1);
    @(posedge clk_i); #1;

    op_wait(OP_SUB, 32'd3, 32'd5, lat);
    chkv("sub_out", out_o, 32'hFFFF_FFFE);
    chkb("sub_neg", neg_o, 1'b1);
    @(posedge clk_i); #1;

    // Reset in the middle of a multiply.
    in_valid_i = 1'b1; opcode_i = OP_MUL; a_i = 32'd7; b_i = 32'd9;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1 check_reset_vals("midmul_rst");
    @(posedge clk_i); #1 rst_ni = 1'b1;

    op_wait(OP_MUL, 32'h0001_0003, 32'h0000_0005, lat);
    chki("mul_lat", lat, W + 1);
    chkv("mul_out", out_o, 32'h0005_000F);
    @(posedge clk_i); #1;

    op_wait(OP_MUL, 32'h8000_0000, 32'd2, lat);
    chkv("mul_wrap_out", out_o, 32'h0);
    chkb("mul_wrap_zero", zero_o, 1'b1);
    @(posedge clk_i); #1;

    op_wait(OP_DIV, 32'd100, 32'd7, lat);
    chki("div_lat", lat, W + 1);
    chkv("div_out", out_o, 32'd14);
    @(posedge clk_i); #1;

    op_wait(OP_DIV, 32'd5, 32'd0, lat);
    chki("div0_lat", lat, DIV0_LAT);
    chkv("div0_out", out_o, 32'hFFFF_FFFF);
    chkb("div0_divz", divz_o, 1'b1);
    @(posedge clk_i); #1;

    // Backpressure, then a back-to-back accept in the releasing cycle.
    out_ready_i = 1'b0;
    op_wait(OP_ADD, 32'h1234, 32'h1, lat);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chkv("hold_out", out_o, 32'h1235);
      chkb("hold_valid", out_valid_o, 1'b1);
    end
    @(posedge clk_i); #1;
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; opcode_i = OP_XOR; a_i = 32'hF0F0; b_i = 32'h0FF0;
    @(negedge clk_i);
    chkb("b2b_ready", in_ready_o, 1'b1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chkb("b2b_valid", out_valid_o, 1'b1);
    chkv("b2b_out", out_o, 32'hFF00);
    @(posedge clk_i); #1;

    // Flush during the tenth divide cycle.
    in_valid_i = 1'b1; opcode_i = OP_DIV; a_i = 32'd1000; b_i = 32'd3;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1 flush_i = 1'b1;
    @(posedge clk_i); #1 flush_i = 1'b0;
    @(negedge clk_i);
    chkb("flush_valid", out_valid_o, 1'b0);
    chkb("flush_ready", in_ready_o, 1'b1);
    chkv("flush_out_kept", out_o, 32'hFF00);
    seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (out_valid_o) seen++;
    end
    chki("flush_no_result", seen, 0);
    @(posedge clk_i); #1;

    op_wait(4'hF, 32'd5, 32'd6, lat);
    chki("ill_lat", lat, 1);
    chkv("ill_out", out_o, 32'h0);
    chkb("ill_flag", illegal_o, 1'b1);
    @(posedge clk_i); #1;

    // Random traffic with backpressure and occasional flushes.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_i);
      acc = in_valid_i && in_ready_o && !flush_i;
      @(posedge clk_i); #1;
      if (acc || !in_valid_i) begin
        if ($urandom_range(0, 2) == 0) begin
          in_valid_i = 1'b1;
          opcode_i   = 4'($urandom_range(0, 15));
          a_i        = rnd_operand();
          b_i        = rnd_operand();
        end else begin
          in_valid_i = 1'b0;
        end
      end
      out_ready_i = ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 49) == 0);
    end
    in_valid_i  = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    repeat (40) @(posedge clk_i);
    @(negedge clk_i);
    chkb("drain_idle", out_valid_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
